sprite_line_fetcher: RTL and testbench
======================================

Name: sprite_line_fetcher

Overview:
Parametrised, handshaked sprite line fetcher; next generation of the sprite bitmap ROM.
- Returns one SPRITE_W-bit line of a square SPRITE_W×SPRITE_W sprite.
- Supports four orientations plus an independent horizontal mirror.
- Output is registered and held under backpressure.
- Rotated orientations (RIGHT/LEFT) are built by a multi-cycle column gather.
- Sits between the tile/object renderer (requester) and the pixel shifter (consumer).

Parameters:
SPRITE_W, 8, sprite edge length in pixels; power of 2, ≥4
NUM_SPRITES, 16, number of addressable sprite IDs
ID_W, $clog2(NUM_SPRITES), sprite ID width
LINE_W, $clog2(SPRITE_W), line index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_sprite_id  in  ID_W  sprite ID
req_orient  in  2  0=UP, 1=RIGHT, 2=DOWN, 3=LEFT
req_mirror  in  1  reverse output bit order after orientation
req_line  in  LINE_W  output line index i
resp_valid  out  1  resp_data valid
resp_ready  in  1  consumer takes resp_data when resp_valid && resp_ready
resp_data  out  SPRITE_W  line data; active-low (0 = pixel on)
busy  out  1  high while in GATHER

Behaviour:
- Reset is synchronous, active-low, on clk only. Reset values: req_ready=0 during reset, resp_valid=0, resp_data=all ones, busy=0, state=IDLE.
- Storage: R(r) is stored row r; bit c is R(r)[c]; W=SPRITE_W.
- Out-of-range IDs (≥ number of defined sprites) read all ones.
- Transform for line i:
  - UP: L=R(i)
  - DOWN: L=R(W-1-i)
  - RIGHT: L[k]=R(k)[W-1-i]
  - LEFT: L[k]=R(W-1-k)[W-1-i]
  - If req_mirror=1: L[k] ← L[W-1-k], applied after the orientation transform.
- FSM states:
  - IDLE: req_ready=1.
  - HOLD: resp_valid=1; req_ready=resp_ready.
  - GATHER: req_ready=0.
- Accept at cycle T:
  - UP, DOWN, or out-of-range ID: go to HOLD; resp_valid is high at T+1.
  - RIGHT/LEFT (in-range ID): latch the request; go to GATHER with counter k=0.
- GATHER:
  - Each cycle read one ROM row: k for RIGHT, W-1-k for LEFT.
  - Write bit W-1-i of that row into L[k]; increment k.
  - After W cycles (k=W-1 consumed), go to HOLD; resp_valid is high at T+W+1.
- HOLD:
  - resp_data and resp_valid stay stable until resp_ready.
  - On handshake with no new request: go to IDLE.
  - On handshake with a new request accepted the same cycle: process it as if from IDLE, giving back-to-back UP throughput of 1 line/cycle.
- Request inputs are ignored while req_ready=0. The requester holds them until accepted.
- Reset mid-GATHER or mid-HOLD: abort, drop the pending response, clear the cache valid bit.
- Counter k is LINE_W bits; wrap at W-1 is the exit condition, never an overflow.

Optional Feature:
SPRITE_ROT_CACHE_EN
- Defined:
  - Adds a W×W transposed buffer Tc[i][k]=R(k)[W-1-i], with tag = sprite ID and a valid bit.
  - RIGHT/LEFT hit (valid && tag match): 1-cycle path like UP.
    - RIGHT: L=Tc[i].
    - LEFT: L=bit-reverse of Tc[i].
  - Miss: GATHER fills all W buffer lines (column k per cycle), sets tag and valid, then HOLD. Miss latency is unchanged.
  - The cache is orientation-independent.
- Undefined: no buffer; every RIGHT/LEFT request takes W cycles.

Decomposition:
- Package sprite_pkg:
  - orientation localparams ORIENT_UP/RIGHT/DOWN/LEFT
  - FSM state encodings
  - default 8×8 sprite table: 0 heart, 1 sword, 2–3 gnome idle, 4–5 dragon wing up/down, 6 dragon head, 7–8 sheep idle
  - SPRITE_COUNT=9
- Sub-module sprite_bitmap_rom(sprite_id, row) → row data:
  - purely combinational
  - the only width-specific part
  - swapped for other SPRITE_W.

Test Plan:
- UP, id0 (heart), line 2, mirror 0 → resp_data=0x00 at T+1. DOWN, id0, line 0 → 0xE7.
- RIGHT, id1 (sword), line 4 → 0xBF at T+9; busy high for 8 cycles. LEFT, id1, line 4 → 0xFD. RIGHT, id1, line 3 → 0x00.
- UP, id1, line 6, mirror 1 → 0xE3. Out-of-range id 9, RIGHT → 0xFF at T+1, no GATHER.
- Hold resp_ready=0 for 5 cycles after a response → resp_data/resp_valid stable and req_ready=0. Then with resp_ready=1 and a new UP request → next response the following cycle.
- Drop reset low at GATHER cycle 4 → next cycle: IDLE, resp_valid=0, busy=0. The following RIGHT id1 line 4 still takes 9 cycles.
- With SPRITE_ROT_CACHE_EN: RIGHT id1 line 4 (9 cycles), then LEFT id1 line 4 → 0xFD at T+1. RIGHT id0 → miss, 9 cycles.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared orientation codes, fetcher FSM encoding and the default 8x8 sprite table.
// Read by sprite_bitmap_rom and sprite_line_fetcher.
package sprite_pkg;

  localparam logic [1:0] ORIENT_UP    = 2'd0;
  localparam logic [1:0] ORIENT_RIGHT = 2'd1;
  localparam logic [1:0] ORIENT_DOWN  = 2'd2;
  localparam logic [1:0] ORIENT_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StGather,
    StHold
  } fetch_state_e;

  localparam int unsigned SPRITE_COUNT = 9;

  // Row 0 is the most significant byte; pixels are active-low (0 = on).
  localparam logic [63:0] SPRITE_TABLE [SPRITE_COUNT] = '{
    64'h9900_0000_81C3_E7E7,  // 0 heart
    64'hEFEF_EFEF_EFEF_C7EF,  // 1 sword
    64'hE7C3_E781_A5E7_DBDB,  // 2 gnome idle a
    64'hE7C3_E781_A5E7_DBBD,  // 3 gnome idle b
    64'h7E3C_1800_81C3_E7FF,  // 4 dragon wing up
    64'hFFE7_C381_0018_3C7E,  // 5 dragon wing down
    64'hF1E0_C080_0307_0F9F,  // 6 dragon head
    64'hFF81_0000_0081_DBDB,  // 7 sheep idle a
    64'hFF81_0000_0081_BDBD   // 8 sheep idle b
  };

endpackage

// File: rtl/sprite_bitmap_rom.sv
// Combinational sprite row lookup; the only part tied to the sprite edge length.
// IDs without a table entry, and unsupported widths, read all ones (transparent).
module sprite_bitmap_rom
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned LINE_W   = 3
) (
  input  logic [ID_W-1:0]     sprite_id,
  input  logic [LINE_W-1:0]   row,
  output logic [SPRITE_W-1:0] row_data
);

  if (SPRITE_W == 8) begin : g_w8
    always_comb begin
      row_data = '1;
      for (int s = 0; s < int'(SPRITE_COUNT); s++) begin
        if (int'(sprite_id) == s) begin
          row_data = SPRITE_TABLE[s][8 * (7 - int'(row)) +: 8];
        end
      end
    end
  end else begin : g_blank
    assign row_data = '1;
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Handshaked sprite line fetcher: UP/DOWN in one cycle, RIGHT/LEFT by a W-cycle column gather.
// Define SPRITE_ROT_CACHE_EN to add a transposed buffer that makes repeat rotated fetches 1-cycle.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned ID_W        = $clog2(NUM_SPRITES),
  parameter int unsigned LINE_W      = $clog2(SPRITE_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ID_W-1:0]     req_sprite_id,
  input  logic [1:0]          req_orient,
  input  logic                req_mirror,
  input  logic [LINE_W-1:0]   req_line,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [SPRITE_W-1:0] resp_data,
  output logic                busy
);

  localparam logic [LINE_W-1:0] LineMax = LINE_W'(SPRITE_W - 1);

  function automatic logic [SPRITE_W-1:0] bit_rev(input logic [SPRITE_W-1:0] x);
    logic [SPRITE_W-1:0] r;
    for (int b = 0; b < int'(SPRITE_W); b++) r[b] = x[int'(SPRITE_W) - 1 - b];
    return r;
  endfunction

  fetch_state_e        state_q, state_d;
  logic [SPRITE_W-1:0] resp_data_q, resp_data_d;
  logic [LINE_W-1:0]   k_q, k_d;
  logic [ID_W-1:0]     lat_id_q;
  logic [1:0]          lat_orient_q;
  logic                lat_mirror_q;
  logic [LINE_W-1:0]   lat_line_q;

  logic                accept, id_in_range, req_rotated, cache_hit, fast_path, gather_done;
  logic [ID_W-1:0]     rom_id;
  logic [LINE_W-1:0]   rom_row, req_rom_row, gather_row, gather_pos;
  logic [SPRITE_W-1:0] rom_data, cache_line, oriented_line, fast_line;

  assign accept      = req_valid && req_ready;
  assign id_in_range = 32'(req_sprite_id) < SPRITE_COUNT;
  assign gather_done = (k_q == LineMax);
  // Out-of-range IDs are all ones in any orientation, so they never need a gather.
  assign fast_path   = !id_in_range || !req_rotated || cache_hit;
  assign gather_row  = (lat_orient_q == ORIENT_LEFT) ? LineMax - k_q : k_q;
  assign gather_pos  = lat_mirror_q ? LineMax - k_q : k_q;

  always_comb begin
    req_rom_row = req_line;
    req_rotated = 1'b0;
    case (req_orient)
      ORIENT_UP:                 req_rom_row = req_line;
      ORIENT_DOWN:               req_rom_row = LineMax - req_line;
      ORIENT_RIGHT, ORIENT_LEFT: req_rotated = 1'b1;
      default:                   req_rotated = 1'b0;
    endcase
  end

  always_comb begin
    if (state_q == StGather) begin
      rom_id  = lat_id_q;
      rom_row = gather_row;
    end else begin
      rom_id  = req_sprite_id;
      rom_row = req_rom_row;
    end
  end

  sprite_bitmap_rom #(
    .SPRITE_W (SPRITE_W),
    .ID_W     (ID_W),
    .LINE_W   (LINE_W)
  ) u_rom (
    .sprite_id (rom_id),
    .row       (rom_row),
    .row_data  (rom_data)
  );

`ifdef SPRITE_ROT_CACHE_EN
  // tc_q[i] is line i of the RIGHT view; LEFT is its bit reverse.
  logic [SPRITE_W-1:0][SPRITE_W-1:0] tc_q;
  logic [ID_W-1:0]                   tag_q;
  logic                              tc_valid_q;

  assign cache_hit  = tc_valid_q && (tag_q == req_sprite_id);
  assign cache_line = (req_orient == ORIENT_LEFT) ? bit_rev(tc_q[req_line]) : tc_q[req_line];

  always_ff @(posedge clk) begin
    if (!reset) begin
      tc_valid_q <= 1'b0;
    end else if (accept && !fast_path) begin
      tc_valid_q <= 1'b0;
    end else if (state_q == StGather && gather_done) begin
      tc_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !fast_path) tag_q <= req_sprite_id;
    if (state_q == StGather) begin
      for (int i = 0; i < int'(SPRITE_W); i++) begin
        tc_q[i][gather_row] <= rom_data[int'(SPRITE_W) - 1 - i];
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_line = '1;
`endif

  always_comb begin
    if (!id_in_range)     oriented_line = '1;
    else if (req_rotated) oriented_line = cache_line;
    else                  oriented_line = rom_data;
    fast_line = req_mirror ? bit_rev(oriented_line) : oriented_line;
  end

  always_comb begin
    resp_data_d = resp_data_q;
    k_d         = k_q;
    if (state_q == StGather) begin
      resp_data_d[gather_pos] = rom_data[LineMax - lat_line_q];
      k_d                     = k_q + 1'b1;
    end
    if (accept) begin
      k_d = '0;
      if (fast_path) resp_data_d = fast_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_data_q  <= '1;
      k_q          <= '0;
      lat_id_q     <= '0;
      lat_orient_q <= ORIENT_UP;
      lat_mirror_q <= 1'b0;
      lat_line_q   <= '0;
    end else begin
      resp_data_q <= resp_data_d;
      k_q         <= k_d;
      if (accept) begin
        lat_id_q     <= req_sprite_id;
        lat_orient_q <= req_orient;
        lat_mirror_q <= req_mirror;
        lat_line_q   <= req_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = fast_path ? StHold : StGather;
      end
      StHold: begin
        if (accept)          state_d = fast_path ? StHold : StGather;
        else if (resp_ready) state_d = StIdle;
      end
      StGather: begin
        if (gather_done) state_d = StHold;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: req_ready = reset;
      StHold: begin
        resp_valid = reset;
        req_ready  = reset && resp_ready;
      end
      StGather: busy = 1'b1;
      default: ;
    endcase
  end

  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher; expected lines are hand-derived from the sprite table.
// Builds with or without SPRITE_ROT_CACHE_EN; rotated hit latency follows the macro.
module tb_sprite_line_fetcher;

`ifdef SPRITE_ROT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_sprite_id = '0;
  logic [1:0] req_orient = '0;
  logic       req_mirror = 1'b0;
  logic [2:0] req_line = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, bcnt;

  sprite_line_fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sprite_id (req_sprite_id),
    .req_orient    (req_orient),
    .req_mirror    (req_mirror),
    .req_line      (req_line),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge; the caller ensures req_ready is high.
  task automatic send_req(input logic [3:0] id, input logic [1:0] ori, input logic mir,
                          input logic [2:0] line);
    req_sprite_id = id;
    req_orient    = ori;
    req_mirror    = mir;
    req_line      = line;
    req_valid     = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until resp_valid; 20+ means it never came.
  task automatic wait_resp(output int l, output int b);
    l = 1;
    b = 0;
    forever begin
      if (busy) b++;
      if (resp_valid || l >= 20) break;
      step();
      l++;
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (resp_data !== 8'hFF) $display("FAIL rst_data: got %h want ff", resp_data); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_up_down();
    send_req(4'd0, 2'd0, 1'b0, 3'd2);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 1) $display("FAIL up_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (resp_data !== 8'h00) $display("FAIL up_data: got %h want 00", resp_data); else n_pass++;
    take();
    send_req(4'd0, 2'd2, 1'b0, 3'd0);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 1) $display("FAIL down_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (resp_data !== 8'hE7) $display("FAIL down_data: got %h want e7", resp_data); else n_pass++;
    take();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL down_release: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_rotate();
    send_req(4'd1, 2'd1, 1'b0, 3'd4);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 9) $display("FAIL right_lat: got %0d want 9", lat); else n_pass++;
    n_checks++; if (bcnt !== 8) $display("FAIL right_busy: got %0d want 8", bcnt); else n_pass++;
    n_checks++; if (resp_data !== 8'hBF) $display("FAIL right_data: got %h want bf", resp_data); else n_pass++;
    take();
    send_req(4'd1, 2'd3, 1'b0, 3'd4);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== HIT_LAT) $display("FAIL left_lat: got %0d want %0d", lat, HIT_LAT); else n_pass++;
    n_checks++; if (resp_data !== 8'hFD) $display("FAIL left_data: got %h want fd", resp_data); else n_pass++;
    take();
    send_req(4'd1, 2'd1, 1'b0, 3'd3);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== HIT_LAT) $display("FAIL right3_lat: got %0d want %0d", lat, HIT_LAT); else n_pass++;
    n_checks++; if (resp_data !== 8'h00) $display("FAIL right3_data: got %h want 00", resp_data); else n_pass++;
    take();
  endtask

  task automatic test_mirror_oor();
    send_req(4'd1, 2'd0, 1'b1, 3'd6);
    wait_resp(lat, bcnt);
    n_checks++; if (resp_data !== 8'hE3) $display("FAIL mirror_data: got %h want e3", resp_data); else n_pass++;
    take();
    send_req(4'd9, 2'd1, 1'b0, 3'd2);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 1) $display("FAIL oor_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (bcnt !== 0) $display("FAIL oor_busy: got %0d want 0", bcnt); else n_pass++;
    n_checks++; if (resp_data !== 8'hFF) $display("FAIL oor_data: got %h want ff", resp_data); else n_pass++;
    take();
  endtask

  task automatic test_backpressure();
    send_req(4'd0, 2'd0, 1'b0, 3'd0);
    req_line  = 3'd7;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", c, resp_valid); else n_pass++;
      n_checks++; if (resp_data !== 8'h99) $display("FAIL bp_data[%0d]: got %h want 99", c, resp_data); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", c, req_ready); else n_pass++;
      step();
    end
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 8'hE7) $display("FAIL bp_next_data: got %h want e7", resp_data); else n_pass++;
    step();
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_idle: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_lines [3];
    exp_lines = '{8'h81, 8'hC3, 8'hE7};
    resp_ready = 1'b1;
    req_sprite_id = 4'd0;
    req_orient = 2'd0;
    req_mirror = 1'b0;
    req_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      req_line = 3'(4 + j);
      step();
      n_checks++; if (resp_data !== exp_lines[j] || resp_valid !== 1'b1)
        $display("FAIL b2b_data[%0d]: got %h/%b want %h/1", j, resp_data, resp_valid, exp_lines[j]);
      else n_pass++;
    end
    req_valid = 1'b0;
    step();
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_idle: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_gather();
    send_req(4'd0, 2'd1, 1'b0, 3'd0);
    step();
    step();
    step();
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL mid_gather: got busy %b ready %b want 1 0", busy, req_ready);
    else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", resp_valid); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_idle: got %b want 1", req_ready); else n_pass++;
    send_req(4'd1, 2'd1, 1'b0, 3'd4);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 9) $display("FAIL post_abort_lat: got %0d want 9", lat); else n_pass++;
    n_checks++; if (resp_data !== 8'hBF) $display("FAIL post_abort_data: got %h want bf", resp_data); else n_pass++;
    take();
  endtask

  task automatic test_cache();
    send_req(4'd0, 2'd1, 1'b0, 3'd0);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 9) $display("FAIL miss_lat: got %0d want 9", lat); else n_pass++;
    n_checks++; if (resp_data !== 8'hF1) $display("FAIL miss_data: got %h want f1", resp_data); else n_pass++;
    take();
    send_req(4'd0, 2'd3, 1'b0, 3'd0);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== HIT_LAT) $display("FAIL hit_lat: got %0d want %0d", lat, HIT_LAT); else n_pass++;
    n_checks++; if (resp_data !== 8'h8F) $display("FAIL hit_data: got %h want 8f", resp_data); else n_pass++;
    take();
    send_req(4'd1, 2'd1, 1'b0, 3'd4);
    wait_resp(lat, bcnt);
    n_checks++; if (lat !== 9) $display("FAIL retag_lat: got %0d want 9", lat); else n_pass++;
    n_checks++; if (resp_data !== 8'hBF) $display("FAIL retag_data: got %h want bf", resp_data); else n_pass++;
    take();
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_rotate();
    test_mirror_oor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_gather();
    test_cache();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
